// File: rtl/depp_master_pkg.sv
// depp_master_pkg: shared widths and FSM state encoding for the DEPP master
package depp_master_pkg;
  localparam int DEPP_DATA_WIDTH = 8;
  localparam int DEPP_ADDR_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, A_SETUP, A_STB, A_REL, D_SETUP, D_STB, D_REL, DONE} depp_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer; clk/rst in, d_i async input, q_o synchronized output
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk)
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/depp_master.sv
// depp_master: EPP register master; cmd_* valid/ready request, rsp_* one-cycle response, usb* active-low EPP bus with timeout abort
module depp_master
  import depp_master_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [DEPP_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DEPP_DATA_WIDTH-1:0] cmd_wdata,
  output logic                       rsp_valid,
  output logic [DEPP_DATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_timeout,
  input  logic                       usbWait,
  inout  wire  [DEPP_DATA_WIDTH-1:0] usbData,
  output logic                       usbAddrStrobe_n,
  output logic                       usbDataStrobe_n,
  output logic                       usbWE_n
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + SETUP_CYCLES + 1);
  depp_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic write_q, to_q, to_d, wait_s, accept, setup_done, expired, a_phase, d_phase;
  logic [DEPP_ADDR_WIDTH-1:0] addr_q;
  logic [DEPP_DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_d;
  sync_2ff #(.W(1)) u_sync (.clk(clk), .rst(rst), .d_i(usbWait), .q_o(wait_s));
  assign accept     = cmd_valid && cmd_ready;
  assign setup_done = cnt_q == CW'(SETUP_CYCLES - 1);
  assign expired    = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = A_SETUP;
        to_d    = 1'b0;
      end
      A_SETUP: state_d = setup_done ? A_STB : A_SETUP;
      A_STB: if (wait_s) state_d = A_REL;
      else if (expired) begin
        state_d = DONE;
        to_d    = 1'b1;
      end
      A_REL: if (!wait_s) state_d = D_SETUP;
      else if (expired) begin
        state_d = DONE;
        to_d    = 1'b1;
      end
      D_SETUP: state_d = setup_done ? D_STB : D_SETUP;
      D_STB: if (wait_s) begin
        state_d = D_REL;
        rdata_d = write_q ? rdata_q : usbData;
      end else if (expired) begin
        state_d = DONE;
        to_d    = 1'b1;
      end
      D_REL: if (!wait_s) state_d = DONE;
      else if (expired) begin
        state_d = DONE;
        to_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // every state starts counting from zero; idle never counts
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
    end
  // strobes and WE_n decode straight from the state, so a timeout or reset drops them on the very next edge
  assign a_phase         = state_q inside {A_SETUP, A_STB, A_REL};
  assign d_phase         = state_q inside {D_SETUP, D_STB, D_REL};
  assign usbAddrStrobe_n = state_q != A_STB;
  assign usbDataStrobe_n = state_q != D_STB;
  assign usbWE_n         = !(a_phase || (d_phase && write_q));
  assign usbData         = usbWE_n ? 'z : (a_phase ? addr_q : wdata_q);
  assign cmd_ready       = state_q == IDLE && !wait_s && !rst;
  assign rsp_valid       = state_q == DONE;
  assign rsp_timeout     = rsp_valid && to_q;
  assign rsp_rdata       = rdata_q;
endmodule
